// File: rtl/spike_if.sv
// Sample-in / result-out handshake bundle for spike_detect_ctrl.
// slave = the detector, master = the sample source / result consumer.
interface spike_if #(
  parameter int DATA_W = 32
) ();
  logic                     s_valid;
  logic                     s_ready;
  logic signed [DATA_W-1:0] s_data;
  logic                     m_valid;
  logic                     m_ready;
  logic                     m_spike;
  logic                     m_warm;
  logic signed [DATA_W-1:0] m_mean;

  modport slave (
    input  s_valid, s_data, m_ready,
    output s_ready, m_valid, m_spike, m_warm, m_mean
  );

  modport master (
    output s_valid, s_data, m_ready,
    input  s_ready, m_valid, m_spike, m_warm, m_mean
  );
endinterface

// File: rtl/spike_detect_ctrl.sv
// Running-mean spike detector: IDLE -> CALC -> OUT per sample, window of 2^WIN_LOG2.
// Optional macro SPIKE_REFRACT_EN enables refractory suppression after each flagged spike.
module spike_detect_ctrl #(
  parameter int unsigned T        = 100,
  parameter int unsigned WIN_LOG2 = 3,
  parameter int unsigned REFRACT  = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clear,
  spike_if.slave      bus,
  output logic [15:0] spike_count,
  output logic        refract_active
);

  localparam int DATA_W = 32;
  localparam int DIFF_W = DATA_W + 1;
  localparam int SUM_W  = DATA_W + WIN_LOG2;
  localparam int FILL_W = WIN_LOG2 + 1;
  localparam int N      = 1 << WIN_LOG2;

  localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(N);
  localparam logic [DIFF_W-1:0] THRESH    = DIFF_W'(T);

  typedef enum logic [1:0] {IDLE, CALC, OUT} state_t;

  state_t state_q, state_d;

  logic signed [DATA_W-1:0] win_buf [N];
  logic signed [SUM_W-1:0]  sum_q;
  logic [FILL_W-1:0]        fill_q;
  logic [WIN_LOG2-1:0]      wr_ptr_q;

  logic signed [DATA_W-1:0] x_p0;
  logic signed [DATA_W-1:0] mean_p0;
  logic [DIFF_W-1:0]        abs_p0;
  logic                     warm_p0;
  logic                     raw_p0;
  logic                     spike_p0;
  logic signed [SUM_W-1:0]  sum_nxt_p0;

  logic signed [DATA_W-1:0] mean_p1;
  logic                     spike_p1;
  logic                     warm_p1;

  function automatic logic signed [DATA_W-1:0] window_mean(input logic signed [SUM_W-1:0] s);
    logic signed [SUM_W-1:0] sh;
    sh = s >>> WIN_LOG2;
    return sh[DATA_W-1:0];
  endfunction

  // Widened by one bit so extreme operands cannot overflow the difference.
  function automatic logic [DIFF_W-1:0] abs_diff(input logic signed [DATA_W-1:0] x,
                                                 input logic signed [DATA_W-1:0] m);
    logic signed [DIFF_W-1:0] d;
    d = {x[DATA_W-1], x} - {m[DATA_W-1], m};
    if (d[DIFF_W-1]) abs_diff = -d;
    else             abs_diff = d;
  endfunction

  function automatic logic [15:0] sat_inc16(input logic [15:0] c);
    return (c == 16'hFFFF) ? c : c + 16'd1;
  endfunction

  function automatic logic signed [SUM_W-1:0] sext_sum(input logic signed [DATA_W-1:0] v);
    return {{WIN_LOG2{v[DATA_W-1]}}, v};
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (clear) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE:    if (bus.s_valid) state_d = CALC;
        CALC:    state_d = OUT;
        OUT:     if (bus.m_ready) state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  assign bus.s_ready = (state_q == IDLE);
  assign bus.m_valid = (state_q == OUT);
  assign bus.m_spike = spike_p1;
  assign bus.m_warm  = warm_p1;
  assign bus.m_mean  = mean_p1;

  // ---- stage p0: sample capture ----
  always_ff @(posedge clk) begin
    if (state_q == IDLE && bus.s_valid && !clear) x_p0 <= bus.s_data;
  end

  // ---- stage p0 -> p1: compare against mean of the preceding window ----
  always_comb begin
    mean_p0 = window_mean(sum_q);
    abs_p0  = abs_diff(x_p0, mean_p0);
    warm_p0 = (fill_q == FILL_FULL);
    raw_p0  = (abs_p0 >= THRESH);
    if (warm_p0) sum_nxt_p0 = sum_q - sext_sum(win_buf[wr_ptr_q]) + sext_sum(x_p0);
    else         sum_nxt_p0 = sum_q + sext_sum(x_p0);
  end

`ifdef SPIKE_REFRACT_EN
  logic [7:0] refract_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      refract_q <= '0;
    end else if (clear) begin
      refract_q <= '0;
    end else if (state_q == CALC) begin
      if (spike_p0)               refract_q <= 8'(REFRACT);
      else if (refract_q != 8'd0) refract_q <= refract_q - 8'd1;
    end
  end

  assign refract_active = (refract_q != 8'd0);
  assign spike_p0       = raw_p0 & warm_p0 & ~refract_active;
`else
  assign refract_active = 1'b0 && (REFRACT != 0);
  assign spike_p0       = raw_p0 & warm_p0;
`endif

  // Buffer holds no reset: entries beyond fill are never read into the sum.
  always_ff @(posedge clk) begin
    if (state_q == CALC && !clear) win_buf[wr_ptr_q] <= x_p0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum_q       <= '0;
      fill_q      <= '0;
      wr_ptr_q    <= '0;
      spike_count <= '0;
      mean_p1     <= '0;
      spike_p1    <= 1'b0;
      warm_p1     <= 1'b0;
    end else if (clear) begin
      sum_q       <= '0;
      fill_q      <= '0;
      wr_ptr_q    <= '0;
      spike_count <= '0;
    end else if (state_q == CALC) begin
      sum_q    <= sum_nxt_p0;
      wr_ptr_q <= wr_ptr_q + 1'b1;
      if (!warm_p0) fill_q <= fill_q + 1'b1;
      if (spike_p0) spike_count <= sat_inc16(spike_count);
      mean_p1  <= mean_p0;
      spike_p1 <= spike_p0;
      warm_p1  <= warm_p0;
    end
  end

endmodule
